// File: rtl/ghost_controller_if.sv
// Ghost controller bus: SoC PIO words, Pac-Man position, wall ROM port and
// ghost tile outputs toward the sprite renderer.
interface ghost_controller_if;
    logic        frame_tick;
    logic [15:0] ghost_direction;
    logic [4:0]  pac_x;
    logic [4:0]  pac_y;
    logic [9:0]  wall_addr;
    logic        wall_data;
    logic [19:0] ghost_x;
    logic [19:0] ghost_y;
    logic [15:0] ghost_status;

    // Environment side: SoC, Pac-Man logic and the wall ROM
    modport master (
        output frame_tick, ghost_direction, pac_x, pac_y, wall_data,
        input  wall_addr, ghost_x, ghost_y, ghost_status
    );

    // Controller side
    modport slave (
        input  frame_tick, ghost_direction, pac_x, pac_y, wall_data,
        output wall_addr, ghost_x, ghost_y, ghost_status
    );
endinterface

// File: rtl/ghost_controller.sv
// Ghost movement engine: once per frame, steps four ghosts one tile each,
// checking the wall ROM, wrapping through the tunnel and flagging collisions
// with Pac-Man. Results are returned through a status word.
module ghost_controller #(
    parameter int GRID_W = 28,
    parameter int GRID_H = 31,
    parameter int HOME_X = 12,
    parameter int HOME_Y = 14
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    ghost_controller_if.slave  bus
);

    localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
    localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, EVAL, COLLIDE, PUBLISH} state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  g;
    logic [11:0] dir_q;
    logic [4:0]  pos_x [4];
    logic [4:0]  pos_y [4];
    logic [3:0]  blocked;
    logic [3:0]  collide;
    logic [3:0]  frame_cnt;
    logic        overrun;
    logic [15:0] status_q;

    logic [3:0]  enable;
    logic [1:0]  dir_g;
    logic [4:0]  cur_x;
    logic [4:0]  cur_y;
    logic [4:0]  tgt_x;
    logic [4:0]  tgt_y;
    logic        legal;

    assign enable = dir_q[11:8];
    assign dir_g  = dir_q[{g, 1'b0} +: 2];
    assign cur_x  = pos_x[g];
    assign cur_y  = pos_y[g];

    // Target tile of ghost g; an illegal vertical move leaves the target on the current tile
    always_comb begin
        tgt_x = cur_x;
        tgt_y = cur_y;
        legal = 1'b1;
        case (dir_g)
            2'b00: begin
                if (cur_y == 5'd0) legal = 1'b0;
                else               tgt_y = cur_y - 5'd1;
            end
            2'b01: begin
                if (cur_y == Y_MAX) legal = 1'b0;
                else                tgt_y = cur_y + 5'd1;
            end
            2'b10: begin
                if (cur_x == 5'd0) tgt_x = X_MAX;
                else               tgt_x = cur_x - 5'd1;
            end
            default: begin
                if (cur_x == X_MAX) tgt_x = 5'd0;
                else                tgt_x = cur_x + 5'd1;
            end
        endcase
    end

    // Wall ROM address is only meaningful while a ghost is being evaluated
    assign bus.wall_addr = (state == ISSUE || state == EVAL) ? {tgt_y, tgt_x} : 10'd0;

    // Busy is live; everything else in the status word is the last published value
    assign bus.ghost_status = {status_q[15:9], (state != IDLE), status_q[7:0]};

    // Pack ghost coordinates into the renderer buses
    always_comb begin
        bus.ghost_x = '0;
        bus.ghost_y = '0;
        for (int i = 0; i < 4; i++) begin
            bus.ghost_x[5*i +: 5] = pos_x[i];
            bus.ghost_y[5*i +: 5] = pos_y[i];
        end
    end

    // Next-state logic for the per-frame update sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.frame_tick) state_nx = ISSUE;
            ISSUE:   state_nx = EVAL;
            EVAL:    state_nx = (g == 2'd3) ? COLLIDE : ISSUE;
            COLLIDE: state_nx = PUBLISH;
            PUBLISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= IDLE;
        else                state <= state_nx;
    end

    // Ghost index and direction latch; direction is captured only on an accepted tick
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            g     <= 2'd0;
            dir_q <= 12'd0;
        end else if (state == IDLE && bus.frame_tick) begin
            g     <= 2'd0;
            dir_q <= bus.ghost_direction[11:0];
        end else if (state == EVAL && g != 2'd3) begin
            g <= g + 2'd1;
        end
    end

    // Ghost positions and blocked flags, updated in EVAL once wall data is valid
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 4; i++) begin
                pos_x[i] <= 5'(HOME_X + i);
                pos_y[i] <= 5'(HOME_Y);
            end
            blocked <= 4'd0;
        end else if (state == EVAL) begin
            if (enable[g]) begin
                if (legal && !bus.wall_data) begin
                    pos_x[g]   <= tgt_x;
                    pos_y[g]   <= tgt_y;
                    blocked[g] <= 1'b0;
                end else begin
                    blocked[g] <= 1'b1;
                end
            end else begin
                blocked[g] <= 1'b0;
            end
        end
    end

    // Collision test against the freshly updated positions
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            collide <= 4'd0;
        end else if (state == COLLIDE) begin
            for (int i = 0; i < 4; i++)
                collide[i] <= enable[i] && (pos_x[i] == bus.pac_x) && (pos_y[i] == bus.pac_y);
        end
    end

    // Overrun capture, frame counter and status publish; a tick during PUBLISH carries to the next frame
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overrun   <= 1'b0;
            frame_cnt <= 4'd0;
            status_q  <= 16'd0;
        end else if (state == PUBLISH) begin
            status_q  <= {frame_cnt + 4'd1, 2'b00, overrun, 1'b0, collide, blocked};
            frame_cnt <= frame_cnt + 4'd1;
            overrun   <= bus.frame_tick;
        end else if (state != IDLE && bus.frame_tick) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ghost_controller.sv
// Directed bench for ghost_controller: reset, movement, walls, edges,
// tunnel wrap, collision, overrun and frame counter.
module tb_ghost_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [1023:0] wall_mem;

    ghost_controller_if bus ();

    ghost_controller #(
        .GRID_W (28),
        .GRID_H (31),
        .HOME_X (12),
        .HOME_Y (14)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous wall ROM with one-cycle latency
    always @(posedge clk) bus.wall_data <= wall_mem[bus.wall_addr];

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Tick is sampled at the next posedge; returns at the first negedge after it
    task automatic pulse_tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    // One full frame; returns when the new status is visible
    task automatic run_frame();
        pulse_tick();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.ghost_status !== 16'h0000) begin
            errors++; $display("FAIL reset_status got %h want %h", bus.ghost_status, 16'h0000);
        end
        bus.ghost_direction = 16'h0FE4;
        pulse_tick();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ghost_status[8] !== 1'b1) begin
            errors++; $display("FAIL midframe_busy got %b want 1", bus.ghost_status[8]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ghost_x !== {5'd15, 5'd14, 5'd13, 5'd12}) begin
            errors++; $display("FAIL reset_x got %h want %h", bus.ghost_x, {5'd15, 5'd14, 5'd13, 5'd12});
        end
        checks++;
        if (bus.ghost_y !== {4{5'd14}}) begin
            errors++; $display("FAIL reset_y got %h want %h", bus.ghost_y, {4{5'd14}});
        end
        checks++;
        if (bus.ghost_status !== 16'h0000) begin
            errors++; $display("FAIL reset_mid_status got %h want %h", bus.ghost_status, 16'h0000);
        end
        checks++;
        if (bus.wall_addr !== 10'd0) begin
            errors++; $display("FAIL reset_wall_addr got %h want 0", bus.wall_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_open_move();
        do_reset();
        bus.ghost_direction = 16'h0FE4;
        pulse_tick();
        bus.ghost_direction = 16'h0000;
        @(negedge clk);
        checks++;
        if (bus.ghost_y[4:0] !== 5'd14) begin
            errors++; $display("FAIL open_g0_early got %0d want 14", bus.ghost_y[4:0]);
        end
        @(negedge clk);
        checks++;
        if (bus.ghost_y[4:0] !== 5'd13) begin
            errors++; $display("FAIL open_g0_t3 got %0d want 13", bus.ghost_y[4:0]);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (bus.ghost_status !== 16'h0100) begin
            errors++; $display("FAIL open_busy_t10 got %h want %h", bus.ghost_status, 16'h0100);
        end
        @(negedge clk);
        checks++;
        if (bus.ghost_x !== {5'd16, 5'd13, 5'd13, 5'd12}) begin
            errors++; $display("FAIL open_x got %h want %h", bus.ghost_x, {5'd16, 5'd13, 5'd13, 5'd12});
        end
        checks++;
        if (bus.ghost_y !== {5'd14, 5'd14, 5'd15, 5'd13}) begin
            errors++; $display("FAIL open_y got %h want %h", bus.ghost_y, {5'd14, 5'd14, 5'd15, 5'd13});
        end
        checks++;
        if (bus.ghost_status !== 16'h1000) begin
            errors++; $display("FAIL open_status got %h want %h", bus.ghost_status, 16'h1000);
        end
    endtask

    task automatic test_walls();
        do_reset();
        wall_mem[{5'd13, 5'd12}] = 1'b1;
        bus.ghost_direction = 16'h0100;
        run_frame();
        checks++;
        if (bus.ghost_x[4:0] !== 5'd12 || bus.ghost_y[4:0] !== 5'd14) begin
            errors++; $display("FAIL wall_pos got (%0d,%0d) want (12,14)", bus.ghost_x[4:0], bus.ghost_y[4:0]);
        end
        checks++;
        if (bus.ghost_status !== 16'h1001) begin
            errors++; $display("FAIL wall_status got %h want %h", bus.ghost_status, 16'h1001);
        end
        wall_mem[{5'd13, 5'd12}] = 1'b0;
    endtask

    task automatic test_y_edge();
        do_reset();
        bus.ghost_direction = 16'h0100;
        repeat (14) run_frame();
        checks++;
        if (bus.ghost_y[4:0] !== 5'd0 || bus.ghost_status !== 16'hE000) begin
            errors++; $display("FAIL edge_reach got y=%0d st=%h want y=0 st=e000", bus.ghost_y[4:0], bus.ghost_status);
        end
        run_frame();
        checks++;
        if (bus.ghost_y[4:0] !== 5'd0 || bus.ghost_x[4:0] !== 5'd12) begin
            errors++; $display("FAIL edge_pos got (%0d,%0d) want (12,0)", bus.ghost_x[4:0], bus.ghost_y[4:0]);
        end
        checks++;
        if (bus.ghost_status !== 16'hF001) begin
            errors++; $display("FAIL edge_status got %h want %h", bus.ghost_status, 16'hF001);
        end
    endtask

    task automatic test_tunnel();
        do_reset();
        bus.ghost_direction = 16'h0420;
        repeat (14) run_frame();
        checks++;
        if (bus.ghost_x[14:10] !== 5'd0) begin
            errors++; $display("FAIL tunnel_x0 got %0d want 0", bus.ghost_x[14:10]);
        end
        run_frame();
        checks++;
        if (bus.ghost_x[14:10] !== 5'd27 || bus.ghost_y[14:10] !== 5'd14) begin
            errors++; $display("FAIL tunnel_wrap got (%0d,%0d) want (27,14)", bus.ghost_x[14:10], bus.ghost_y[14:10]);
        end
        checks++;
        if (bus.ghost_status !== 16'hF000) begin
            errors++; $display("FAIL tunnel_status got %h want %h", bus.ghost_status, 16'hF000);
        end
    endtask

    task automatic test_collision();
        do_reset();
        bus.pac_x = 5'd13;
        bus.pac_y = 5'd14;
        wall_mem[{5'd15, 5'd13}] = 1'b1;
        bus.ghost_direction = 16'h0204;
        run_frame();
        checks++;
        if (bus.ghost_status !== 16'h1022) begin
            errors++; $display("FAIL collide_on got %h want %h", bus.ghost_status, 16'h1022);
        end
        bus.ghost_direction = 16'h0004;
        run_frame();
        checks++;
        if (bus.ghost_status !== 16'h2000) begin
            errors++; $display("FAIL collide_off got %h want %h", bus.ghost_status, 16'h2000);
        end
        checks++;
        if (bus.ghost_x[9:5] !== 5'd13 || bus.ghost_y[9:5] !== 5'd14) begin
            errors++; $display("FAIL collide_pos got (%0d,%0d) want (13,14)", bus.ghost_x[9:5], bus.ghost_y[9:5]);
        end
        wall_mem[{5'd15, 5'd13}] = 1'b0;
        bus.pac_x = 5'd31;
        bus.pac_y = 5'd31;
    endtask

    task automatic test_overrun();
        do_reset();
        bus.ghost_direction = 16'h0000;
        pulse_tick();
        repeat (3) @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.ghost_status !== 16'h1200) begin
            errors++; $display("FAIL overrun_set got %h want %h", bus.ghost_status, 16'h1200);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.ghost_status !== 16'h1200) begin
            errors++; $display("FAIL overrun_dropped got %h want %h", bus.ghost_status, 16'h1200);
        end
        run_frame();
        checks++;
        if (bus.ghost_status !== 16'h2000) begin
            errors++; $display("FAIL overrun_clear got %h want %h", bus.ghost_status, 16'h2000);
        end
        pulse_tick();
        repeat (9) @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        checks++;
        if (bus.ghost_status !== 16'h3000) begin
            errors++; $display("FAIL overrun_publish_tick got %h want %h", bus.ghost_status, 16'h3000);
        end
        run_frame();
        checks++;
        if (bus.ghost_status !== 16'h4200) begin
            errors++; $display("FAIL overrun_carried got %h want %h", bus.ghost_status, 16'h4200);
        end
    endtask

    task automatic test_frame_cnt();
        do_reset();
        bus.ghost_direction = 16'h0000;
        repeat (17) run_frame();
        checks++;
        if (bus.ghost_status !== 16'h1000) begin
            errors++; $display("FAIL frame_cnt_wrap got %h want %h", bus.ghost_status, 16'h1000);
        end
    endtask

    initial begin
        wall_mem            = '0;
        bus.frame_tick      = 1'b0;
        bus.ghost_direction = 16'h0000;
        bus.pac_x           = 5'd31;
        bus.pac_y           = 5'd31;
        test_reset();
        test_open_move();
        test_walls();
        test_y_edge();
        test_tunnel();
        test_collision();
        test_overrun();
        test_frame_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
